regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32: implemented registers, legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter NUM_RD, default 2: independent read ports, legal range 1..4.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: write-back strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: write-back destination.
REQ-009 SHALL have port wr_data, input, DATA_W bits: write-back data.
REQ-010 SHALL have port iss_en, input, 1 bit: an instruction issues and claims a destination.
REQ-011 SHALL have port iss_addr, input, ADDR_W bits: destination being claimed.
REQ-012 SHALL have port flush, input, 1 bit: discard all outstanding claims.
REQ-013 SHALL have port rd_addr, input, NUM_RD x ADDR_W bits: read addresses.
REQ-014 SHALL have port rd_data, output, NUM_RD x DATA_W bits: read data.
REQ-015 SHALL have port rd_busy, output, NUM_RD bits: read register has a pending producer.
REQ-016 SHALL have port busy_cnt, output, $clog2(NUM_REGS+1) bits: count of busy registers.

Function
REQ-017 Register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-018 Addresses >= NUM_REGS SHALL read 0, report not busy, and be ignored for writes and issues.
REQ-019 Reads SHALL be combinational from rd_addr, with zero-cycle latency.
REQ-020 A write (wr_en=1) SHALL update the register at the next rising edge of clk.
REQ-021 A write SHALL clear the register's busy bit at the same edge.
REQ-022 An issue (iss_en=1) SHALL set the busy bit of iss_addr at the next edge.
REQ-023 Issue to an already-busy register SHALL leave it busy and SHALL NOT increment busy_cnt.
REQ-024 Issue and write to the same address in one cycle: data SHALL be written and the busy bit SHALL end set, because the new producer wins.
REQ-025 flush=1 SHALL clear all busy bits at the next edge.
REQ-026 flush together with iss_en: busy SHALL afterwards hold only iss_addr (issue applied after flush).
REQ-027 busy_cnt SHALL be a registered count equal to the population of busy bits after every edge.
REQ-028 busy_cnt SHALL be maintained incrementally (+1, -1, 0 per event pair), not by a popcount.
REQ-029 Multiple read ports addressing the same register SHALL return identical data.

Reset
REQ-030 While rst=1: all registers SHALL be 0, all busy bits 0, and busy_cnt 0, immediately and without waiting for clk.
REQ-031 Reset SHALL override any write, issue or flush in progress.
REQ-032 The first edge after rst deasserts SHALL process inputs normally.

Configuration
REQ-033 Macro REGFILE_SB_BYPASS_EN defined: a read port whose rd_addr equals wr_addr while wr_en=1 SHALL return wr_data in the same cycle.
REQ-034 With REGFILE_SB_BYPASS_EN defined, that read port's rd_busy SHALL read 0 unless iss_en targets the same address.
REQ-035 With REGFILE_SB_BYPASS_EN defined, register 0 and out-of-range addresses SHALL still read 0.
REQ-036 Macro REGFILE_SB_BYPASS_EN undefined: rd_data and rd_busy SHALL reflect registered state only, so write data is visible one cycle after the write.

Structure
REQ-037 A shared package regfile_pkg SHALL hold default DATA_W/ADDR_W/NUM_REGS constants and the zero-register index constant.
REQ-038 The busy bits and busy_cnt SHALL live in one sub-module, regfile_scoreboard; data storage and read muxing SHALL remain in regfile_sb.

Verification
REQ-039 Reset test: write x5=0x64, assert rst mid-cycle -> rd_data for x5 = 0 immediately and busy_cnt=0.
REQ-040 Zero-register test: write x0=0xDEADBEEF, issue x0 -> rd_data for x0 = 0, rd_busy=0, busy_cnt=0.
REQ-041 Scoreboard test: issue x3, x7, then x3 again -> busy_cnt=2; write x3=0x11 -> busy_cnt=1, x3 reads 0x11 and is not busy.
REQ-042 Simultaneous test: same cycle issue x9 and write x9=0x22 -> x9=0x22, rd_busy=1, busy_cnt unchanged+1 if x9 was previously free.
REQ-043 Flush test: issue x1, x2, x4, then flush with issue x6 -> busy_cnt=1, only x6 busy.
REQ-044 Bypass test: write x10=0xA5A5A5A5 while reading x10 -> read returns 0xA5A5A5A5 the same cycle with REGFILE_SB_BYPASS_EN defined, and the old value that cycle without it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;
    localparam int ZERO_REG     = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer and keeps a running count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:1] busy,
    output logic [CNT_W-1:0]    busy_cnt
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_iss_hit;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;
    logic                w_set;
    logic                w_clr;

    // Bit 0 and out-of-range addresses never hit, so they can never become busy.
    always_comb begin
        w_wr_hit  = '0;
        w_iss_hit = '0;
        for (int i = ZERO_REG + 1; i < NUM_REGS; i++) begin
            w_wr_hit[i]  = wr_en && (wr_addr == ADDR_W'(i));
            w_iss_hit[i] = iss_en && (iss_addr == ADDR_W'(i));
        end
    end

    always_comb begin
        w_busy_d = r_busy;
        if (flush) begin
            w_busy_d = w_iss_hit;
        end else begin
            w_busy_d = (r_busy & ~w_wr_hit) | w_iss_hit;
        end
        w_set = |(w_iss_hit & ~r_busy);
        w_clr = |(w_wr_hit & r_busy & ~w_iss_hit);
        if (flush) begin
            w_cnt_d = CNT_W'(|w_iss_hit);
        end else begin
            w_cnt_d = r_cnt + CNT_W'(w_set) - CNT_W'(w_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_cnt  <= w_cnt_d;
        end
    end

    assign busy     = r_busy[NUM_REGS-1:1];
    assign busy_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and combinational read ports.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_W-1:0]              iss_addr,
    input  logic                           flush,
    input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]       rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    output logic [$clog2(NUM_REGS+1)-1:0]  busy_cnt
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    // Register 0 has no storage; it is the constant zero.
    logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] w_busy;
    logic [ADDR_W-1:0]   w_ra;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Unmatched addresses (zero register, out of range) fall through to the zero defaults.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_ra    = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra = rd_addr[p*ADDR_W +: ADDR_W];
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_ra == ADDR_W'(i)) begin
                    rd_data[p*DATA_W +: DATA_W] = r_regs[i];
                    rd_busy[p]                  = w_busy[i];
`ifdef REGFILE_SB_BYPASS_EN
                    if (wr_en && (wr_addr == w_ra)) begin
                        rd_data[p*DATA_W +: DATA_W] = wr_data;
                        rd_busy[p]                  = iss_en && (iss_addr == w_ra);
                    end
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes model expectations, a monitor compares.
module tb_regfile_sb;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 24;
    localparam int NUM_RD   = 2;
    localparam int CNT_W    = $clog2(NUM_REGS + 1);

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       wr_en = 1'b0;
    logic [ADDR_W-1:0]          wr_addr = '0;
    logic [DATA_W-1:0]          wr_data = '0;
    logic                       iss_en = 1'b0;
    logic [ADDR_W-1:0]          iss_addr = '0;
    logic                       flush = 1'b0;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;
    logic [CNT_W-1:0]           busy_cnt;

    regfile_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                      name;
        logic [NUM_RD*DATA_W-1:0]   data;
        logic [NUM_RD-1:0]          busy;
        logic [CNT_W-1:0]           cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic bit m_valid(input logic [ADDR_W-1:0] a);
        return (a != 0) && (int'(a) < NUM_REGS);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, advance the model at the edge.
    task automatic step(input string name, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                        input logic fl, input logic [4:0] r0, input logic [4:0] r1);
        exp_t        e;
        logic [4:0]  ra [2];
        logic [31:0] d;
        logic        b;
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; flush = fl;
        rd_addr = {r1, r0};
        ra[0] = r0;
        ra[1] = r1;
        if (rst) model_clear();
        e.name = name;
        e.cnt  = CNT_W'(m_count());
        e.data = '0;
        e.busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            d = '0;
            b = 1'b0;
            if (m_valid(ra[p])) begin
                d = m_regs[ra[p]];
                b = m_busy[ra[p]];
`ifdef REGFILE_SB_BYPASS_EN
                if (we && wa == ra[p]) begin
                    d = wd;
                    b = ie && (ia == ra[p]);
                end
`endif
            end
            e.data[p*DATA_W +: DATA_W] = d;
            e.busy[p] = b;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (we && m_valid(wa)) m_regs[wa] = wd;
            if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (we && m_valid(wa)) m_busy[wa] = 1'b0;
            if (ie && m_valid(ia)) m_busy[ia] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input string name, input logic [4:0] r0, input logic [4:0] r1);
        step(name, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rd_data !== e.data) begin
                    n_err++;
                    $display("FAIL %s rd_data: got %h expected %h", e.name, rd_data, e.data);
                end
                n_cmp++;
                if (rd_busy !== e.busy) begin
                    n_err++;
                    $display("FAIL %s rd_busy: got %b expected %b", e.name, rd_busy, e.busy);
                end
                n_cmp++;
                if (busy_cnt !== e.cnt) begin
                    n_err++;
                    $display("FAIL %s busy_cnt: got %0d expected %0d", e.name, busy_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        model_clear();
        @(posedge clk);
        #1;
        step("reset_state", 1'b1, 5'd5, 32'h99, 1'b1, 5'd5, 1'b0, 5'd5, 5'd3);
        rst = 1'b0;

        step("wr_x5", 1'b1, 5'd5, 32'h64, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        idle("rd_x5", 5'd5, 5'd0);
        step("iss_x5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd9);
        idle("busy_x5", 5'd5, 5'd9);
        rst = 1'b1;
        step("rst_mid", 1'b1, 5'd5, 32'h77, 1'b1, 5'd9, 1'b1, 5'd5, 5'd9);
        rst = 1'b0;
        step("post_rst_wr", 1'b1, 5'd5, 32'h12, 1'b1, 5'd9, 1'b0, 5'd5, 5'd9);
        idle("post_rst_rd", 5'd5, 5'd9);

        step("x0_wr_iss", 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        idle("x0_rd", 5'd0, 5'd0);

        step("iss_x3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd7);
        step("iss_x7", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd3, 5'd7);
        step("iss_x3_again", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd7);
        idle("sb_cnt2", 5'd3, 5'd7);
        step("wr_x3", 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7);
        idle("sb_x3_free", 5'd3, 5'd7);

        step("sim_x9", 1'b1, 5'd9, 32'h22, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        idle("sim_x9_rd", 5'd9, 5'd7);
        step("sim_x9_busy", 1'b1, 5'd9, 32'h33, 1'b1, 5'd9, 1'b0, 5'd9, 5'd7);
        idle("sim_x9_rd2", 5'd9, 5'd7);

        step("iss_x1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2);
        step("iss_x2", 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
        step("iss_x4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd6);
        step("flush_iss6", 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1, 5'd1, 5'd6);
        idle("flush_rd", 5'd6, 5'd4);
        idle("flush_rd2", 5'd1, 5'd9);

        step("wr_x10_old", 1'b1, 5'd10, 32'h5A5A5A5A, 1'b0, 5'd0, 1'b0, 5'd10, 5'd10);
        step("byp_x10", 1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd10, 5'd10);
        step("byp_x10_iss", 1'b1, 5'd10, 32'h0BADF00D, 1'b1, 5'd10, 1'b0, 5'd10, 5'd6);
        idle("x10_rd", 5'd10, 5'd6);

        step("oor_wr_iss", 1'b1, 5'd25, 32'hCAFE, 1'b1, 5'd30, 1'b0, 5'd25, 5'd30);
        idle("oor_rd", 5'd25, 5'd30);

        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
            rst = 1'b0;
        end
        idle("final", 5'd1, 5'd2);

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
